// File: rtl/cmd_packet_sequencer_if.sv
// Host-side byte stream and command-bus outputs of cmd_packet_sequencer.
// The DUT connects through slave; the host side, or a bench, uses master.
interface cmd_packet_sequencer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_byte;
    logic          busy;
    logic          drop_pulse;
    logic [LW-1:0] level;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_byte, busy, drop_pulse, level
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_byte, busy, drop_pulse, level
    );
endinterface

// File: rtl/cmd_packet_sequencer.sv
// Buffers host command bytes and replays only fully buffered packets onto the command bus.
// Parameter bytes go out back to back, and idle cycles follow each packet.
module cmd_packet_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    cmd_packet_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;
    logic [7:0]    head;
    logic          head_bad;
    logic [2:0]    head_len;

    state_e        state_q, state_d;
    logic [1:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    out_q, out_d;
    logic          drop_q, drop_d;

    assign bus.in_ready   = (level_q != LW'(DEPTH));
    assign push           = bus.in_valid & bus.in_ready;
    assign head           = mem[rd_ptr_q];
    assign bus.out_byte   = out_q;
    assign bus.drop_pulse = drop_q;
    assign bus.level      = level_q;
    assign bus.busy       = (level_q != '0) || (state_q != StIdle);

    always_comb begin
        head_bad = 1'b0;
        head_len = 3'd4;
        if (!head[7] || head[6:5] == 2'b00) begin
            head_bad = 1'b1;
            head_len = 3'd1;
        end else if (head[6:5] == 2'b01) begin
            head_len = (head[4:0] == 5'h1f) ? 3'd1 : 3'd2;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is not reset; only the pointers and the count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        out_d   = 8'h00;
        drop_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    if (head_bad) begin
                        pop    = 1'b1;
                        drop_d = 1'b1;
                    end else if (level_q >= LW'(head_len)) begin
                        pop     = 1'b1;
                        out_d   = head;
                        rem_d   = 2'(head_len - 3'd1);
                        gap_d   = '0;
                        state_d = (head_len == 3'd1) ? StGap : StSend;
                    end
                end
            end
            StSend: begin
                // Every parameter byte is already buffered, so the FIFO cannot run dry here.
                pop   = 1'b1;
                out_d = {3'b100, head[4:0]};
                rem_d = rem_q - 2'd1;
                if (rem_q == 2'd1) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            gap_q   <= '0;
            out_q   <= 8'h00;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_cmd_packet_sequencer.sv
// Scoreboard bench for cmd_packet_sequencer: a host model queues the expected command-bus
// bytes as each packet completes, and a negedge monitor checks them against the output.
module tb_cmd_packet_sequencer;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned GAP_CYCLES = 1;

    typedef struct {
        logic [7:0] val;
        bit         last;
    } exp_t;

    logic clk;
    logic rst_n;

    cmd_packet_sequencer_if #(.DEPTH(DEPTH)) bus ();

    cmd_packet_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_errors;
    exp_t       exp_q[$];
    logic [7:0] pend[$];
    int         p_rem;
    int         model_drops;
    int         drop_cnt;
    int         zero_run;
    bit         mid_pkt;
    bit         after_pkt;
    bit         saw_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The host's view of the protocol: a packet's bytes become expected output once complete.
    task automatic model_accept(input logic [7:0] b);
        int len;
        if (p_rem == 0) begin
            if (!b[7] || b[6:5] == 2'b00) begin
                model_drops++;
                return;
            end
            if (b[6:5] == 2'b01) len = (b[4:0] == 5'h1f) ? 1 : 2;
            else len = 4;
            pend.delete();
            pend.push_back(b);
            p_rem = len - 1;
        end else begin
            pend.push_back({3'b100, b[4:0]});
            p_rem--;
        end
        if (p_rem == 0) begin
            for (int i = 0; i < pend.size(); i++) begin
                exp_t e;
                e.val  = pend[i];
                e.last = (i == pend.size() - 1);
                exp_q.push_back(e);
            end
            pend.delete();
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int tries = 0; tries < 100 && !taken; tries++) begin
            taken = bus.in_ready;
            @(posedge clk);
            if (taken) model_accept(b);
            @(negedge clk);
        end
        if (!taken) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.busy;
        end
        check(tag, 32'(done), 32'(1));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_byte != 8'h00) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(bus.out_byte), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (!mid_pkt && after_pkt) begin
                        check("gap_len", 32'(zero_run >= GAP_CYCLES), 32'(1));
                    end
                    check("out_byte", 32'(bus.out_byte), 32'(e.val));
                    mid_pkt = !e.last;
                    if (e.last) begin
                        after_pkt = 1'b1;
                        zero_run  = 0;
                    end
                end
            end else begin
                if (mid_pkt) begin
                    check("consecutive", 32'(bus.out_byte),
                          32'(exp_q.size() > 0 ? exp_q[0].val : 8'hff));
                    mid_pkt = 1'b0;
                end
                zero_run++;
            end
            if (bus.drop_pulse) drop_cnt++;
            if (bus.level == DEPTH) saw_full = 1'b1;
            check("ready_vs_level", 32'(bus.in_ready), 32'(bus.level != DEPTH));
            check("level_bound", 32'(bus.level <= DEPTH), 32'(1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops_before;
        bit seen;
        n_checks     = 0;
        n_errors     = 0;
        p_rem        = 0;
        model_drops  = 0;
        drop_cnt     = 0;
        zero_run     = 0;
        mid_pkt      = 1'b0;
        after_pkt    = 1'b0;
        saw_full     = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(bus.out_byte), 32'(0));
        check("rst_level", 32'(bus.level), 32'(0));
        check("rst_ready", 32'(bus.in_ready), 32'(1));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_drop", 32'(bus.drop_pulse), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // CLEAR: single-byte packet with exact latency
        send_byte(8'hbf);
        bus.in_valid = 1'b0;
        check("clr_latency", 32'(bus.out_byte), 32'(0));
        check("clr_busy", 32'(bus.busy), 32'(1));
        @(negedge clk);
        check("clr_out", 32'(bus.out_byte), 32'(8'hbf));
        @(negedge clk);
        check("clr_gap", 32'(bus.out_byte), 32'(0));
        check("clr_idle", 32'(bus.busy), 32'(0));
        wait_drain("clr_drain");

        // DRAW_LINE from a slow host
        send_byte(8'hc3);
        idle(3);
        send_byte(8'h05);
        idle(1);
        send_byte(8'he2);
        send_byte(8'h07);
        wait_drain("draw_drain");

        // Malformed headers are dropped, then a 2-byte packet
        drops_before = drop_cnt;
        send_byte(8'h45);
        send_byte(8'h81);
        send_byte(8'ha2);
        send_byte(8'h03);
        wait_drain("mal_drain");
        check("mal_drops", 32'(drop_cnt - drops_before), 32'(2));
        check("drops_model", 32'(drop_cnt), 32'(model_drops));

        // Continuous 4-byte packets outrun the drain and fill the FIFO
        for (int i = 0; i < 16; i++) begin
            logic [7:0] h;
            h = 8'hc0 | 8'(i);
            send_byte(h);
            send_byte(8'(i * 3));
            send_byte(8'(i + 7));
            send_byte(8'(8'hf0 ^ i));
        end
        wait_drain("bp_drain");
        check("bp_full_seen", 32'(saw_full), 32'(1));

        // FILL_RECT then CLEAR preloaded back to back
        send_byte(8'he1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'hbf);
        wait_drain("b2b_drain");

        // Reset in the middle of a 4-byte packet
        send_byte(8'he1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.out_byte == 8'h81) seen = 1'b1;
            else @(negedge clk);
        end
        check("mid_send_seen", 32'(seen), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(bus.out_byte), 32'(0));
        check("mid_rst_level", 32'(bus.level), 32'(0));
        check("mid_rst_busy", 32'(bus.busy), 32'(0));
        exp_q.delete();
        pend.delete();
        p_rem     = 0;
        mid_pkt   = 1'b0;
        after_pkt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hbf);
        bus.in_valid = 1'b0;
        check("post_rst_latency", 32'(bus.out_byte), 32'(0));
        @(negedge clk);
        check("post_rst_clr", 32'(bus.out_byte), 32'(8'hbf));
        wait_drain("post_rst_drain");

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
